// File: rtl/byte_bus_arbiter_if.sv
// Byte bus arbiter interface: groups the requester, handshake and grant signals.
// The slave modport is the arbiter side; the master modport is the environment
// (requesters and downstream consumer). Optional lock input when
// BYTE_ARB_LOCK_EN is defined.
interface byte_bus_arbiter_if;
    logic       req_a;
    logic       req_b;
    logic [7:0] data_a;
    logic [7:0] data_b;
    logic       out_ready;
    logic       gnt_a;
    logic       gnt_b;
    logic       sel;
    logic [7:0] out_data;
    logic       out_valid;
    logic       busy;
`ifdef BYTE_ARB_LOCK_EN
    logic       lock;
`endif

    modport slave (
`ifdef BYTE_ARB_LOCK_EN
        input  lock,
`endif
        input  req_a,
        input  req_b,
        input  data_a,
        input  data_b,
        input  out_ready,
        output gnt_a,
        output gnt_b,
        output sel,
        output out_data,
        output out_valid,
        output busy
    );

    modport master (
`ifdef BYTE_ARB_LOCK_EN
        output lock,
`endif
        output req_a,
        output req_b,
        output data_a,
        output data_b,
        output out_ready,
        input  gnt_a,
        input  gnt_b,
        input  sel,
        input  out_data,
        input  out_valid,
        input  busy
    );
endinterface

// File: rtl/byte_bus_arbiter.sv
// Round-robin arbiter sharing one 8-bit byte path between requesters A and B.
// Each grant is limited to MAX_BURST beats; the selected byte is captured in a
// registered output stage with a valid/ready handshake.
// Optional feature macro: BYTE_ARB_LOCK_EN (adds a lock input that lets the
// granted requester ignore the burst limit until its request drops).
module byte_bus_arbiter #(
    parameter int MAX_BURST = 4,
    parameter int CNT_W     = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    byte_bus_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_A = 2'd1,
        GRANT_B = 2'd2
    } state_e;

    // Count value of the final beat in a burst.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BURST - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_b_q, last_b_d;   // 1: B was served last
    logic             sel_q, sel_d;
    logic [7:0]       out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;

    logic             own_req_s;
    logic             other_req_s;
    logic [7:0]       mux_byte_s;
    logic             accept_s;
    logic             beat_s;
    logic             limit_s;
    logic             release_s;
    logic             lock_s;

`ifdef BYTE_ARB_LOCK_EN
    assign lock_s = bus.lock;
`else
    assign lock_s = 1'b0;
`endif

    // Steer the owner's request, the competitor's request and the owner's byte.
    always_comb begin
        own_req_s   = 1'b0;
        other_req_s = 1'b0;
        mux_byte_s  = bus.data_a;
        case (state_q)
            GRANT_A: begin
                own_req_s   = bus.req_a;
                other_req_s = bus.req_b;
                mux_byte_s  = bus.data_a;
            end
            GRANT_B: begin
                own_req_s   = bus.req_b;
                other_req_s = bus.req_a;
                mux_byte_s  = bus.data_b;
            end
            default: begin
                own_req_s   = 1'b0;
                other_req_s = 1'b0;
                mux_byte_s  = bus.data_a;
            end
        endcase
    end

    // The output stage can take a byte when empty or when its byte leaves now.
    assign accept_s  = !out_valid_q || bus.out_ready;
    assign beat_s    = (state_q != IDLE) && own_req_s && accept_s;
    // Burst limit counts beats only; a held lock suspends it.
    assign limit_s   = (cnt_q == LAST_CNT) && !lock_s;
    assign release_s = (state_q != IDLE) && ((beat_s && limit_s) || !own_req_s);

    // Next-state logic: round-robin choice in IDLE, bounded bursts when granted.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        last_b_d = last_b_q;
        case (state_q)
            IDLE: begin
                cnt_d = {CNT_W{1'b0}};
                if (bus.req_a && bus.req_b) begin
                    state_d = last_b_q ? GRANT_A : GRANT_B;
                end else if (bus.req_a) begin
                    state_d = GRANT_A;
                end else if (bus.req_b) begin
                    state_d = GRANT_B;
                end else begin
                    state_d = IDLE;
                end
            end
            GRANT_A, GRANT_B: begin
                if (release_s) begin
                    cnt_d = {CNT_W{1'b0}};
                    if (other_req_s) begin
                        state_d  = (state_q == GRANT_A) ? GRANT_B : GRANT_A;
                        last_b_d = (state_q == GRANT_B);
                    end else if (own_req_s) begin
                        state_d = state_q;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (beat_s) begin
                    // Saturates only while locked; otherwise the limit releases first.
                    cnt_d = (cnt_q == LAST_CNT) ? cnt_q : cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                end else begin
                    cnt_d = cnt_q;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = {CNT_W{1'b0}};
            end
        endcase
    end

    // Output stage and mux select: capture on a beat, drain on ready, hold sel when idle.
    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        sel_d       = sel_q;
        if (beat_s) begin
            out_data_d  = mux_byte_s;
            out_valid_d = 1'b1;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
        case (state_d)
            GRANT_A: sel_d = 1'b0;
            GRANT_B: sel_d = 1'b1;
            default: sel_d = sel_q;
        endcase
    end

    // State and datapath registers; reset discards any pending beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= {CNT_W{1'b0}};
            last_b_q    <= 1'b1;
            sel_q       <= 1'b0;
            out_data_q  <= 8'h00;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_b_q    <= last_b_d;
            sel_q       <= sel_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.gnt_a     = (state_q == GRANT_A);
    assign bus.gnt_b     = (state_q == GRANT_B);
    assign bus.busy      = (state_q != IDLE);
    assign bus.sel       = sel_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_byte_bus_arbiter.sv
// Self-checking bench for byte_bus_arbiter: reset/idle checks, a directed
// vector table, a mid-burst reset, and randomized traffic against a
// beat-counting reference model.
module tb_byte_bus_arbiter;
    localparam int MAX_BURST = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    byte_bus_arbiter_if bus ();

    byte_bus_arbiter #(.MAX_BURST(MAX_BURST), .CNT_W(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       ra;
        logic       rb;
        logic [7:0] da;
        logic [7:0] db;
        logic       rdy;
        logic       ga;
        logic       gb;
        logic       sl;
        logic       vl;
        logic [7:0] od;
        logic       bz;
    } vec_t;

    vec_t vt [17];

    // reference model: owner 0 none, 1 A, 2 B; beats counted per grant
    int         m_owner;
    int         m_beats;
    int         m_last;
    logic       m_sel;
    logic       m_valid;
    logic [7:0] m_data;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outs(input string tag, input logic ga, input logic gb, input logic sl,
                              input logic vl, input logic [7:0] od, input logic bz);
        chk({tag, ".gnt_a"},     {7'd0, bus.gnt_a},     {7'd0, ga});
        chk({tag, ".gnt_b"},     {7'd0, bus.gnt_b},     {7'd0, gb});
        chk({tag, ".sel"},       {7'd0, bus.sel},       {7'd0, sl});
        chk({tag, ".out_valid"}, {7'd0, bus.out_valid}, {7'd0, vl});
        chk({tag, ".out_data"},  bus.out_data,          od);
        chk({tag, ".busy"},      {7'd0, bus.busy},      {7'd0, bz});
    endtask

    task automatic model_reset();
        m_owner = 0;
        m_beats = 0;
        m_last  = 2;
        m_sel   = 1'b0;
        m_valid = 1'b0;
        m_data  = 8'h00;
    endtask

    // One clock of the arbitration rules applied to the inputs present at the edge.
    task automatic model_step(input logic ra, input logic rb, input logic [7:0] da,
                              input logic [7:0] db, input logic rdy, input logic lk);
        logic acc, mine, other, beat, done;
        acc = !m_valid || rdy;
        if (m_owner == 0) begin
            if (ra && rb)  m_owner = (m_last == 1) ? 2 : 1;
            else if (ra)   m_owner = 1;
            else if (rb)   m_owner = 2;
            m_beats = 0;
            if (rdy) m_valid = 1'b0;
        end else begin
            mine  = (m_owner == 1) ? ra : rb;
            other = (m_owner == 1) ? rb : ra;
            beat  = mine && acc;
            if (beat) begin
                m_data  = (m_owner == 1) ? da : db;
                m_valid = 1'b1;
                m_beats++;
            end else if (rdy) begin
                m_valid = 1'b0;
            end
            done = !mine || (beat && m_beats >= MAX_BURST && !lk);
            if (done) begin
                if (other) begin
                    m_last  = m_owner;
                    m_owner = 3 - m_owner;
                end else if (!mine) begin
                    m_owner = 0;
                end
                m_beats = 0;
            end
        end
        if (m_owner == 1)      m_sel = 1'b0;
        else if (m_owner == 2) m_sel = 1'b1;
    endtask

    task automatic drive(input logic ra, input logic rb, input logic [7:0] da,
                         input logic [7:0] db, input logic rdy);
        bus.req_a     = ra;
        bus.req_b     = rb;
        bus.data_a    = da;
        bus.data_b    = db;
        bus.out_ready = rdy;
    endtask

    initial begin
        logic       ra, rb, rdy, lk;
        logic [7:0] da, db;

        // ra rb da db rdy | gnt_a gnt_b sel valid data busy
        vt[0]  = '{1'b1, 1'b0, 8'h11, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1};
        vt[1]  = '{1'b1, 1'b0, 8'h11, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h11, 1'b1};
        vt[2]  = '{1'b1, 1'b0, 8'h22, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h22, 1'b1};
        vt[3]  = '{1'b1, 1'b0, 8'h33, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h33, 1'b1};
        vt[4]  = '{1'b1, 1'b0, 8'h44, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h44, 1'b1};
        vt[5]  = '{1'b1, 1'b0, 8'h55, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h55, 1'b1};
        vt[6]  = '{1'b0, 1'b1, 8'h66, 8'h99, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h55, 1'b1};
        vt[7]  = '{1'b0, 1'b1, 8'h00, 8'hb1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'hb1, 1'b1};
        vt[8]  = '{1'b0, 1'b1, 8'h00, 8'hb2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'hb1, 1'b1};
        vt[9]  = '{1'b0, 1'b1, 8'h00, 8'hb2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'hb1, 1'b1};
        vt[10] = '{1'b0, 1'b1, 8'h00, 8'hb2, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'hb2, 1'b1};
        vt[11] = '{1'b0, 1'b1, 8'h00, 8'hb3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'hb3, 1'b1};
        vt[12] = '{1'b1, 1'b1, 8'h00, 8'hb4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'hb4, 1'b1};
        vt[13] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hb4, 1'b0};
        vt[14] = '{1'b0, 1'b1, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'hb4, 1'b1};
        vt[15] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'hb4, 1'b0};
        vt[16] = '{1'b1, 1'b1, 8'ha1, 8'hc1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'hb4, 1'b1};

        // reset and idle
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
`ifdef BYTE_ARB_LOCK_EN
        bus.lock = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check_outs("reset", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check_outs("idle", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        end

        // directed vector table
        for (int i = 0; i < 17; i++) begin
            drive(vt[i].ra, vt[i].rb, vt[i].da, vt[i].db, vt[i].rdy);
            @(posedge clk);
            #1;
            check_outs($sformatf("vec%0d", i), vt[i].ga, vt[i].gb, vt[i].sl, vt[i].vl, vt[i].od, vt[i].bz);
        end

        // reset mid-burst: one beat pending, then async reset clears it at once
        drive(1'b1, 1'b1, 8'h5a, 8'hc1, 1'b0);
        @(posedge clk);
        #1;
        check_outs("preburst", 1'b1, 1'b0, 1'b0, 1'b1, 8'h5a, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_outs("midreset", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // randomized traffic against the model; opens with steady contention
        model_reset();
        ra = 1'b0;
        rb = 1'b0;
        lk = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (i < 24) begin
                ra  = 1'b1;
                rb  = 1'b1;
                rdy = 1'b1;
            end else begin
                if ($urandom_range(0, 7) == 0) ra = ~ra;
                if ($urandom_range(0, 7) == 0) rb = ~rb;
                rdy = ($urandom_range(0, 3) != 0);
            end
            da = 8'($urandom);
            db = 8'($urandom);
`ifdef BYTE_ARB_LOCK_EN
            if ($urandom_range(0, 15) == 0) lk = ~lk;
            bus.lock = lk;
`endif
            drive(ra, rb, da, db, rdy);
            model_step(ra, rb, da, db, rdy, lk);
            @(posedge clk);
            #1;
            check_outs($sformatf("rnd%0d", i), 1'(m_owner == 1), 1'(m_owner == 2), m_sel,
                       m_valid, m_data, 1'(m_owner != 0));
        end

`ifdef BYTE_ARB_LOCK_EN
        // lock holds A past the burst limit; releasing it hands over after one beat
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
        bus.lock = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        bus.lock = 1'b1;
        drive(1'b1, 1'b1, 8'h00, 8'h00, 1'b1);
        @(posedge clk);
        #1;
        check_outs("lock_gnt", 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b1, 8'(i + 1), 8'h00, 1'b1);
            @(posedge clk);
            #1;
            check_outs($sformatf("lock%0d", i), 1'b1, 1'b0, 1'b0, 1'b1, 8'(i + 1), 1'b1);
        end
        bus.lock = 1'b0;
        drive(1'b1, 1'b1, 8'h77, 8'h00, 1'b1);
        @(posedge clk);
        #1;
        check_outs("unlock", 1'b0, 1'b1, 1'b1, 1'b1, 8'h77, 1'b1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
